// File: rtl/sb_pkg.sv
// -----------------------------------------------------------------------------
// sb_pkg
// Shared definitions for the commit store buffer:
//   SZ_BYTE / SZ_HALF / SZ_WORD : store/load size encodings (2'b11 acts as word)
//   sb_entry_t                  : one buffered store {addr, data, size}
//   size_to_mask()              : byte-lane mask of an access within its word
// -----------------------------------------------------------------------------
package sb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } sb_entry_t;

    // Lanes touched inside the aligned 32-bit word. A misaligned access is
    // clipped at the word boundary (bits shifted past lane 3 are dropped).
    function automatic logic [3:0] size_to_mask(input logic [1:0] size,
                                                input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/commit_store_buffer_if.sv
// -----------------------------------------------------------------------------
// commit_store_buffer_if
// Write channel from the store buffer to data memory.
//   dm_write_valid : head entry is presented
//   dm_write_ready : memory accepts the head this cycle
//   dm_addr/dm_data/dm_size : head entry payload
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// valid is high it stays high with a stable payload until ready is sampled
// high. Ready may be asserted while valid is low; it is then ignored.
// -----------------------------------------------------------------------------
interface commit_store_buffer_if;

    logic        dm_write_valid;
    logic        dm_write_ready;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [1:0]  dm_size;

    modport master (
        output dm_write_valid,
        output dm_addr,
        output dm_data,
        output dm_size,
        input  dm_write_ready
    );

    modport slave (
        input  dm_write_valid,
        input  dm_addr,
        input  dm_data,
        input  dm_size,
        output dm_write_ready
    );

endinterface

// File: rtl/sb_fwd_match.sv
// -----------------------------------------------------------------------------
// sb_fwd_match
// Combinational load-to-store forwarding search over the registered entries.
//   i_entries   : entry array
//   i_head      : oldest entry index
//   i_count     : number of valid entries
//   i_reset     : forces all forward results to zero
//   i_ld_valid / i_ld_addr / i_ld_size : load probe
//   o_overlap   : per-entry overlap with the probe (valid entries only)
//   o_fwd_hit / o_fwd_data / o_fwd_conflict : forwarding result
// -----------------------------------------------------------------------------
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  sb_entry_t        i_entries [DEPTH],
    input  logic [PTR_W-1:0] i_head,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_reset,
    input  logic             i_ld_valid,
    input  logic [31:0]      i_ld_addr,
    input  logic [1:0]       i_ld_size,
    output logic [DEPTH-1:0] o_overlap,
    output logic             o_fwd_hit,
    output logic [31:0]      o_fwd_data,
    output logic             o_fwd_conflict
);

    logic [DEPTH-1:0] w_entry_valid;
    logic [3:0]       w_ld_mask;
    logic             w_found;
    logic [PTR_W-1:0] w_sel;

    always_comb begin : overlap_calc
        logic [PTR_W-1:0] age;
        w_entry_valid = '0;
        o_overlap     = '0;
        w_ld_mask     = size_to_mask(i_ld_size, i_ld_addr[1:0]);
        for (int i = 0; i < DEPTH; i++) begin
            // Distance from the head decides validity; works across the wrap.
            age              = PTR_W'(i) - i_head;
            w_entry_valid[i] = (CNT_W'(age) < i_count);
            o_overlap[i]     = w_entry_valid[i]
                && (i_entries[i].addr[31:2] == i_ld_addr[31:2])
                && (|(size_to_mask(i_entries[i].size, i_entries[i].addr[1:0]) & w_ld_mask));
        end
    end

    // Walk oldest to youngest and keep the last overlap seen: this picks the
    // same entry as scanning backward from tail-1, because valid entries are
    // contiguous from the head.
    always_comb begin : youngest_select
        logic [PTR_W-1:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = i_head + PTR_W'(k);
            if (o_overlap[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    always_comb begin
        o_fwd_hit      = 1'b0;
        o_fwd_conflict = 1'b0;
        o_fwd_data     = '0;
        if (!i_reset && i_ld_valid && w_found) begin
            if ((i_entries[w_sel].addr == i_ld_addr) && (i_entries[w_sel].size == i_ld_size)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = i_entries[w_sel].data;
            end else begin
                o_fwd_conflict = 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_store_buffer.sv
// -----------------------------------------------------------------------------
// commit_store_buffer
// Post-commit store buffer: accepts committed stores in program order, drains
// them to data memory over the dm interface, and answers same-cycle load
// lookups by forwarding from the youngest matching store or flagging conflict.
//   CLK, RESET          : clock, synchronous active-high reset
//   store_*_in          : committed store push from retire
//   sb_full/sb_empty/sb_count : occupancy status
//   dm (master)         : head entry write channel to data memory
//   ld_lookup_*         : MEM-stage load probe
//   fwd_hit/fwd_data/fwd_conflict : forwarding result (combinational)
//   overflow_err        : sticky, a push arrived while full
//   dbg_ld_overlap      : per-entry overlap vector of the current probe
// -----------------------------------------------------------------------------
module commit_store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             store_valid_in,
    input  logic [31:0]      store_addr_in,
    input  logic [31:0]      store_data_in,
    input  logic [1:0]       store_size_in,
    output logic             sb_full,
    output logic             sb_empty,
    output logic [CNT_W-1:0] sb_count,
    commit_store_buffer_if.master dm,
    input  logic             ld_lookup_valid,
    input  logic [31:0]      ld_lookup_addr,
    input  logic [1:0]       ld_lookup_size,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             fwd_conflict,
    output logic             overflow_err,
    output logic [DEPTH-1:0] dbg_ld_overlap
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        r_entries [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full comes from the registered count, so a pop in the same cycle does
    // not open a slot for a push.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = store_valid_in && !w_full;
    assign w_pop   = dm.dm_write_valid && dm.dm_write_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (store_valid_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Entry payload needs no reset: validity is carried by head/count.
    always_ff @(posedge CLK) begin
        if (w_push && !RESET) begin
            r_entries[r_tail] <= '{addr: store_addr_in, data: store_data_in, size: store_size_in};
        end
    end

    assign sb_full      = w_full;
    assign sb_empty     = w_empty;
    assign sb_count     = r_count;
    assign overflow_err = r_overflow;

    assign dm.dm_write_valid = !w_empty && !RESET;
    // Payload is zeroed while empty so stale entries never appear on the bus.
    assign dm.dm_addr = w_empty ? '0 : r_entries[r_head].addr;
    assign dm.dm_data = w_empty ? '0 : r_entries[r_head].data;
    assign dm.dm_size = w_empty ? '0 : r_entries[r_head].size;

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_fwd_match (
        .i_entries      (r_entries),
        .i_head         (r_head),
        .i_count        (r_count),
        .i_reset        (RESET),
        .i_ld_valid     (ld_lookup_valid),
        .i_ld_addr      (ld_lookup_addr),
        .i_ld_size      (ld_lookup_size),
        .o_overlap      (dbg_ld_overlap),
        .o_fwd_hit      (fwd_hit),
        .o_fwd_data     (fwd_data),
        .o_fwd_conflict (fwd_conflict)
    );

endmodule

// File: tb/tb_commit_store_buffer.sv
module tb_commit_store_buffer;
    import sb_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             st_v = 1'b0;
    logic [31:0]      st_a = '0;
    logic [31:0]      st_d = '0;
    logic [1:0]       st_s = '0;
    logic             rdy  = 1'b0;
    logic             ld_v = 1'b0;
    logic [31:0]      ld_a = '0;
    logic [1:0]       ld_s = '0;
    logic             sb_full, sb_empty, fwd_hit, fwd_conflict, overflow_err;
    logic [CNT_W-1:0] sb_count;
    logic [31:0]      fwd_data;
    logic [DEPTH-1:0] dbg_ld_overlap;

    commit_store_buffer_if dm_if();
    assign dm_if.dm_write_ready = rdy;

    commit_store_buffer #(.DEPTH(DEPTH)) dut (
        .CLK             (clk),
        .RESET           (rst),
        .store_valid_in  (st_v),
        .store_addr_in   (st_a),
        .store_data_in   (st_d),
        .store_size_in   (st_s),
        .sb_full         (sb_full),
        .sb_empty        (sb_empty),
        .sb_count        (sb_count),
        .dm              (dm_if),
        .ld_lookup_valid (ld_v),
        .ld_lookup_addr  (ld_a),
        .ld_lookup_size  (ld_s),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data),
        .fwd_conflict    (fwd_conflict),
        .overflow_err    (overflow_err),
        .dbg_ld_overlap  (dbg_ld_overlap)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [65:0] exp_q[$];   // {addr, data, size}, oldest at front
    bit          exp_ovf;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'b00) return 1;
        if (sz == 2'b01) return 2;
        return 4;
    endfunction

    // Byte ranges inside one aligned word, clipped at the word end.
    function automatic bit ovl(input logic [31:0] a1, input logic [1:0] s1,
                               input logic [31:0] a2, input logic [1:0] s2);
        int lo1, hi1, lo2, hi2;
        if (a1[31:2] != a2[31:2]) return 0;
        lo1 = int'(a1[1:0]);
        lo2 = int'(a2[1:0]);
        hi1 = ((lo1 + nbytes(s1)) > 4 ? 4 : lo1 + nbytes(s1)) - 1;
        hi2 = ((lo2 + nbytes(s2)) > 4 ? 4 : lo2 + nbytes(s2)) - 1;
        return (lo1 <= hi2) && (lo2 <= hi1);
    endfunction

    task automatic check_outputs();
        logic [65:0] e;
        logic        eh, ec;
        logic [31:0] ed;
        int          n;
        n = exp_q.size();
        chk("sb_count", 32'(sb_count), 32'(n));
        chk("sb_full", 32'(sb_full), 32'(n == DEPTH));
        chk("sb_empty", 32'(sb_empty), 32'(n == 0));
        chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
        chk("dm_write_valid", 32'(dm_if.dm_write_valid), 32'((n != 0) && !rst));
        if (n != 0) begin
            e = exp_q[0];
            chk("dm_addr", dm_if.dm_addr, e[65:34]);
            chk("dm_data", dm_if.dm_data, e[33:2]);
            chk("dm_size", 32'(dm_if.dm_size), 32'(e[1:0]));
        end else begin
            chk("dm_addr_empty", dm_if.dm_addr, 32'h0);
        end
        eh = 1'b0; ec = 1'b0; ed = '0;
        if (!rst && ld_v) begin
            for (int i = n - 1; i >= 0; i--) begin
                e = exp_q[i];
                if (ovl(e[65:34], e[1:0], ld_a, ld_s)) begin
                    if (e[65:34] == ld_a && e[1:0] == ld_s) begin
                        eh = 1'b1;
                        ed = e[33:2];
                    end else begin
                        ec = 1'b1;
                    end
                    break;
                end
            end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(eh));
        chk("fwd_conflict", 32'(fwd_conflict), 32'(ec));
        chk("fwd_data", fwd_data, ed);
    endtask

    task automatic model_edge();
        bit was_full, pop;
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            was_full = (exp_q.size() == DEPTH);
            pop      = (exp_q.size() != 0) && rdy;
            if (st_v && was_full) exp_ovf = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (st_v && !was_full) exp_q.push_back({st_a, st_d, st_s});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic finish_cycle();
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic idle();
        st_v = 1'b0; rdy = 1'b0; ld_v = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_v = 1'b1; st_a = a; st_d = d; st_s = s;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic [1:0]  st_s;
        logic        rdy;
        logic        ld_v;
        logic [31:0] ld_a;
        logic [1:0]  ld_s;
        int          e_cnt;
        logic        e_hit;
        logic        e_conf;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[14];

    initial begin
        // Expected fields are the outputs in the cycle the inputs are applied.
        vt[0]  = '{1'b1, 32'h200, 32'h11111111, SZ_WORD, 1'b0, 1'b0, 32'h0,   SZ_WORD, 0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 32'h200, 32'h22222222, SZ_WORD, 1'b0, 1'b1, 32'h200, SZ_WORD, 1, 1'b1, 1'b0, 32'h11111111};
        vt[2]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h200, SZ_WORD, 2, 1'b1, 1'b0, 32'h22222222};
        vt[3]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h204, SZ_WORD, 2, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b1, 32'h301, 32'h000000AB, SZ_BYTE, 1'b0, 1'b1, 32'h200, SZ_HALF, 2, 1'b0, 1'b1, 32'h0};
        vt[5]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h300, SZ_WORD, 3, 1'b0, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h301, SZ_BYTE, 3, 1'b1, 1'b0, 32'h000000AB};
        vt[7]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h300, SZ_BYTE, 3, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b1, 32'h300, SZ_HALF, 3, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b0, 1'b0, 32'h200, SZ_WORD, 3, 1'b0, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b1, 1'b1, 32'h200, SZ_WORD, 3, 1'b1, 1'b0, 32'h22222222};
        vt[11] = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b1, 1'b1, 32'h200, SZ_WORD, 2, 1'b1, 1'b0, 32'h22222222};
        vt[12] = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b1, 1'b1, 32'h200, SZ_WORD, 1, 1'b0, 1'b0, 32'h0};
        vt[13] = '{1'b0, 32'h0,   32'h0,        SZ_WORD, 1'b1, 1'b0, 32'h0,   SZ_WORD, 0, 1'b0, 1'b0, 32'h0};

        // ---- initial reset ----
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        rst = 1'b0;
        chk("rst_empty", 32'(sb_empty), 32'h1);
        chk("rst_count", 32'(sb_count), 32'h0);
        chk("rst_valid", 32'(dm_if.dm_write_valid), 32'h0);
        chk("rst_ovf", 32'(overflow_err), 32'h0);

        // ---- reset then one store, held while ready=0 ----
        push(32'h100, 32'hDEADBEEF, SZ_WORD);
        tick();
        idle();
        chk("one_valid", 32'(dm_if.dm_write_valid), 32'h1);
        chk("one_addr", dm_if.dm_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", 32'(dm_if.dm_write_valid), 32'h1);
            chk("hold_data", dm_if.dm_data, 32'hDEADBEEF);
        end
        rdy = 1'b1;
        tick();
        idle();
        chk("one_drained", 32'(sb_empty), 32'h1);

        // ---- table-driven forwarding vectors ----
        for (int v = 0; v < 14; v++) begin
            st_v = vt[v].st_v; st_a = vt[v].st_a; st_d = vt[v].st_d; st_s = vt[v].st_s;
            rdy  = vt[v].rdy;  ld_v = vt[v].ld_v; ld_a = vt[v].ld_a; ld_s = vt[v].ld_s;
            @(negedge clk);
            chk($sformatf("vec%0d_count", v), 32'(sb_count), 32'(vt[v].e_cnt));
            chk($sformatf("vec%0d_hit", v), 32'(fwd_hit), 32'(vt[v].e_hit));
            chk($sformatf("vec%0d_conflict", v), 32'(fwd_conflict), 32'(vt[v].e_conf));
            chk($sformatf("vec%0d_data", v), fwd_data, vt[v].e_data);
            finish_cycle();
        end
        idle();

        // ---- fill to DEPTH, overflow, drain across the wrap ----
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h1000 + 32'(4 * i), $urandom, SZ_WORD);
            tick();
        end
        idle();
        chk("fill_full", 32'(sb_full), 32'h1);
        chk("fill_count", 32'(sb_count), 32'(DEPTH));
        push(32'h2000, 32'hBAD0BAD0, SZ_WORD);
        tick();
        chk("ovf_set", 32'(overflow_err), 32'h1);
        chk("ovf_count", 32'(sb_count), 32'(DEPTH));
        // Pop while full: the same-cycle push is still refused.
        push(32'h2004, 32'hBAD1BAD1, SZ_WORD);
        rdy = 1'b1;
        tick();
        chk("full_pop_push", 32'(sb_count), 32'(DEPTH - 1));
        st_v = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        idle();
        chk("fill_drained", 32'(sb_empty), 32'h1);
        chk("ovf_sticky", 32'(overflow_err), 32'h1);

        // ---- steady state at count=3 ----
        for (int i = 0; i < 3; i++) begin
            push(32'h3000 + 32'(4 * i), $urandom, SZ_WORD);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            push(32'h3100 + 32'(4 * i), $urandom, SZ_WORD);
            rdy = 1'b1;
            tick();
            chk("steady_count", 32'(sb_count), 32'h3);
        end
        idle();

        // ---- reset mid-drain at count=5 ----
        for (int i = 0; i < 2; i++) begin
            push(32'h3200 + 32'(4 * i), $urandom, SZ_WORD);
            tick();
        end
        idle();
        chk("pre_rst_count", 32'(sb_count), 32'h5);
        rst = 1'b1;
        rdy = 1'b1;
        ld_v = 1'b1; ld_a = 32'h3200; ld_s = SZ_WORD;
        tick();
        rst = 1'b0;
        idle();
        chk("mid_rst_count", 32'(sb_count), 32'h0);
        chk("mid_rst_valid", 32'(dm_if.dm_write_valid), 32'h0);
        chk("mid_rst_ovf", 32'(overflow_err), 32'h0);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            rst  = ($urandom_range(0, 149) == 0);
            st_v = ($urandom_range(0, 99) < 60);
            st_a = 32'h400 + 32'($urandom_range(0, 15));
            st_d = $urandom;
            st_s = 2'($urandom_range(0, 2));
            rdy  = ($urandom_range(0, 99) < 50);
            ld_v = ($urandom_range(0, 99) < 70);
            ld_a = 32'h400 + 32'($urandom_range(0, 15));
            ld_s = 2'($urandom_range(0, 2));
            tick();
        end
        rst = 1'b0;
        idle();
        rdy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        chk("final_empty", 32'(sb_empty), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_store_buffer.md
# commit_store_buffer

Post-commit store buffer that sits directly downstream of the retire/commit stage. It accepts architecturally committed stores, one per cycle, holds them in program order, and drains them to the data memory over a valid/ready handshake. It also answers same-cycle load lookups from the MEM stage, either by forwarding data from the youngest matching store or by flagging a conflict. Committed stores are non-speculative, so a mispredict recovery never flushes this buffer.

## Interface
- DEPTH, 8: number of entries; must be a power of two, ≥2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- store_valid_in  in  1  committed store presented by retire this cycle.
- store_addr_in  in  32  byte address of the store.
- store_data_in  in  32  store data, right-aligned.
- store_size_in  in  2  size encoding: 00 byte, 01 half, 10 word, 11 treated as word.
- sb_full  out  1  buffer cannot accept a push this cycle; feeds the retire stall.
- sb_empty  out  1  no entries held.
- sb_count  out  CNT_W  current occupancy.
- dm_write_valid  out  1  head entry is presented to data memory.
- dm_write_ready  in  1  data memory accepts the head this cycle.
- dm_addr / dm_data  out  32 each  head entry address and data.
- dm_size  out  2  head entry size.
- ld_lookup_valid  in  1  MEM-stage load is probing the buffer.
- ld_lookup_addr  in  32  load byte address.
- ld_lookup_size  in  2  load size, same encoding as stores.
- fwd_hit  out  1  forward is valid; fwd_data is the load result.
- fwd_data  out  32  forwarded data; 0 when fwd_hit=0.
- fwd_conflict  out  1  the load overlaps a buffered store that cannot be forwarded; the load must replay.
- overflow_err  out  1  sticky; set when a push arrives while sb_full is high.

## Operation
- Storage is a circular FIFO with head, tail and count registers, plus per-entry {addr, data, size}.
- **Push:** if store_valid_in=1 and sb_full=0, write the entry at tail, then tail+1 mod DEPTH.
- **Illegal push:** if store_valid_in=1 and sb_full=1, the store is dropped and overflow_err is set. overflow_err stays set until RESET.
- **Pop:** if dm_write_valid=1 and dm_write_ready=1, head+1 mod DEPTH.
- **Count:** count += push − pop. A simultaneous push and pop leaves count unchanged.
  - When full, a same-cycle pop does not allow a push, because sb_full is derived from the registered count.
  - When empty, a same-cycle push does not pop.
- **Flags and head outputs:**
  - sb_full = (count==DEPTH).
  - sb_empty = (count==0).
  - dm_write_valid = !sb_empty && !RESET.
  - dm_* fields come from entry[head].
- **Byte mask:** mask = size-derived mask shifted by addr[1:0]. Byte = 1 byte, half = 2 bytes, word = 4 bytes. Overlap means equal addr[31:2] and mask AND ≠ 0.
- **Forwarding search:** only registered, valid entries are searched; the head is included even while it is being popped.
- **Forward result** (only when ld_lookup_valid=1 and the youngest overlapping entry is found):
  - If that entry has identical addr and size to the load: fwd_hit=1, fwd_data=entry data.
  - Otherwise: fwd_conflict=1.
  - With no overlap: both outputs are 0, and the load reads the cache.
- **Mutual exclusion:** fwd_hit and fwd_conflict are never both 1.
- **Reset:** at a clock edge with RESET=1, head, tail and count go to 0 and overflow_err goes to 0. Held stores are discarded.
- **Reset values of outputs after reset:**
  - sb_empty=1.
  - All other outputs are 0.
  - Forward outputs are also forced to 0 while RESET=1.

## Timing
- Push to visibility on dm_write_valid: 1 cycle. A store pushed at edge N appears at head after edge N when the buffer was empty.
- Handshake:
  - dm_write_valid, once high, stays high with stable payload until dm_write_ready is sampled high.
  - dm_write_ready is permitted while valid=0 and is then ignored.
- Throughput: one push and one pop per cycle sustained.
- Forward path: combinational from ld_lookup_* and registered entries to fwd_*, with the result in the same cycle. A store pushed in the same cycle is not visible to the lookup.
- Pointer wrap-around: tail DEPTH−1 → 0 and head DEPTH−1 → 0 with no bubble.

## Structure
- Shared package (sb_pkg) holds:
  - the size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the sb_entry_t typedef {addr, data, size};
  - the function size_to_mask(size, addr[1:0]).
- One sub-module, sb_fwd_match. It takes the entry array, head, count and the load probe, and produces a per-entry overlap vector, youngest-match selection (scanning from tail−1 backward to head), fwd_hit, fwd_conflict and fwd_data.

## Test plan
- **Reset then one store:** push word 0x100/0xDEADBEEF with ready=0.
  - Next cycle: dm_write_valid=1, dm_addr=0x100.
  - Holds for 3 cycles; pops when ready=1; then sb_empty=1.
- **Fill to DEPTH with ready=0:**
  - sb_full=1, count=8.
  - An extra push sets overflow_err=1 and is dropped.
  - Draining yields the 8 stores in order across the head/tail wrap.
- **Steady state:** simultaneous push and pop every cycle at count=3 keeps count=3 for 20 cycles. Data order is preserved.
- **Forward hit:** stores word 0x200=0x11111111 then word 0x200=0x22222222.
  - Word load 0x200 gives fwd_hit=1, fwd_data=0x22222222.
  - Load 0x204 gives no hit and no conflict.
- **Forward conflict:** store byte 0x301=0xAB, then load word 0x300: fwd_conflict=1, fwd_hit=0.
- **Reset mid-drain:** RESET with count=5 and valid high.
  - Next cycle: count=0, dm_write_valid=0, overflow_err=0.
